// File: rtl/hc_161.sv
// Synchronous presettable binary counter with trickle-gated terminal count.
// One WIDTH-bit register; tc is decoded combinationally from q and cet.
module hc_161 #(
    parameter int WIDTH = 4
) (
    output logic [WIDTH-1:0] q,
    output logic             tc,
    input  logic             mr,
    input  logic             clk,
    input  logic             cep,
    input  logic             cet,
    input  logic             pe,
    input  logic [WIDTH-1:0] d
);

    localparam logic [WIDTH-1:0] ALL_ONES = '1;

    // Reset beats load, and load beats count.
    always_ff @(posedge clk) begin
        if (!mr) begin
            q <= '0;
        end else if (!pe) begin
            q <= d;
        end else if (cep && cet) begin
            q <= q + WIDTH'(1);
        end
    end

    assign tc = cet && (q == ALL_ONES);

endmodule

// File: tb/tb_hc_161.sv
// Testbench for hc_161: directed vector table, mid-cycle tc checks, and a
// randomized run compared against an arithmetic reference model.
module tb_hc_161;

    localparam int WIDTH = 4;
    localparam int MODULUS = 1 << WIDTH;

    logic [WIDTH-1:0] q;
    logic             tc;
    logic             mr, clk, cep, cet, pe;
    logic [WIDTH-1:0] d;

    int errors = 0;
    int checks = 0;

    hc_161 #(.WIDTH(WIDTH)) dut (
        .q   (q),
        .tc  (tc),
        .mr  (mr),
        .clk (clk),
        .cep (cep),
        .cet (cet),
        .pe  (pe),
        .d   (d)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic             mr;
        logic             pe;
        logic             cep;
        logic             cet;
        logic [WIDTH-1:0] d;
        logic [WIDTH-1:0] exp_q;
        logic             exp_tc;
        string            name;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic m, input logic p, input logic ep, input logic et,
                                input int dv, input int eq, input logic etc, input string nm);
        vec_t v;
        v.mr = m; v.pe = p; v.cep = ep; v.cet = et;
        v.d = WIDTH'(dv); v.exp_q = WIDTH'(eq); v.exp_tc = etc; v.name = nm;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic m, input logic p, input logic ep, input logic et,
                         input logic [WIDTH-1:0] dv);
        mr = m; pe = p; cep = ep; cet = et; d = dv;
    endtask

    // Reference: next q from the priority rules, using plain integer arithmetic.
    function automatic int model_next(input int cur, input logic m, input logic p,
                                      input logic ep, input logic et, input int dv);
        if (m == 1'b0) return 0;
        if (p == 1'b0) return dv;
        if (ep && et) return (cur + 1) % MODULUS;
        return cur;
    endfunction

    initial begin
        int model_q;
        logic exp_tc;

        drive(1'b1, 1'b1, 1'b1, 1'b1, '0);

        vecs.push_back(mk(0, 1, 1, 1, 0, 0, 0, "reset_1"));
        vecs.push_back(mk(0, 1, 1, 1, 0, 0, 0, "reset_2"));
        vecs.push_back(mk(1, 1, 1, 1, 0, 1, 0, "count_1"));
        vecs.push_back(mk(1, 1, 1, 1, 0, 2, 0, "count_2"));
        vecs.push_back(mk(1, 1, 1, 1, 0, 3, 0, "count_3"));
        vecs.push_back(mk(1, 0, 1, 1, 9, 9, 0, "load_wins_over_count"));
        vecs.push_back(mk(1, 1, 1, 1, 0, 10, 0, "count_after_load_10"));
        vecs.push_back(mk(1, 1, 1, 1, 0, 11, 0, "count_after_load_11"));
        vecs.push_back(mk(1, 0, 0, 1, 14, 14, 0, "load_14"));
        vecs.push_back(mk(1, 1, 1, 1, 0, 15, 1, "reach_15_tc"));
        vecs.push_back(mk(1, 1, 1, 1, 0, 0, 0, "wrap_to_0"));
        vecs.push_back(mk(1, 0, 0, 1, 15, 15, 1, "load_15_tc_next_cycle"));
        vecs.push_back(mk(1, 1, 1, 0, 0, 15, 0, "cet_low_holds_15"));
        vecs.push_back(mk(1, 0, 1, 0, 15, 15, 0, "load_15_cet_low"));
        vecs.push_back(mk(1, 0, 0, 0, 5, 5, 0, "load_5"));
        vecs.push_back(mk(1, 1, 0, 1, 0, 5, 0, "cep_low_hold_1"));
        vecs.push_back(mk(1, 1, 0, 1, 0, 5, 0, "cep_low_hold_2"));
        vecs.push_back(mk(1, 1, 0, 1, 0, 5, 0, "cep_low_hold_3"));
        vecs.push_back(mk(1, 1, 0, 1, 0, 5, 0, "cep_low_hold_4"));
        vecs.push_back(mk(1, 1, 1, 0, 0, 5, 0, "cet_low_hold"));
        vecs.push_back(mk(1, 1, 1, 1, 0, 6, 0, "both_high_6"));
        vecs.push_back(mk(0, 0, 1, 1, 7, 0, 0, "reset_beats_load"));
        vecs.push_back(mk(1, 1, 1, 1, 0, 1, 0, "resume_1"));
        vecs.push_back(mk(1, 1, 1, 1, 0, 2, 0, "resume_2"));
        vecs.push_back(mk(0, 1, 1, 1, 0, 0, 0, "reset_mid_count"));
        vecs.push_back(mk(1, 1, 1, 1, 0, 1, 0, "resume_from_0"));

        foreach (vecs[i]) begin
            drive(vecs[i].mr, vecs[i].pe, vecs[i].cep, vecs[i].cet, vecs[i].d);
            @(posedge clk);
            #1;
            chk({vecs[i].name, "_q"}, 32'(q), 32'(vecs[i].exp_q));
            chk({vecs[i].name, "_tc"}, 32'(tc), 32'(vecs[i].exp_tc));
        end

        // Between edges: tc tracks cet at once, ignores other inputs; q is untouched.
        drive(1'b1, 1'b0, 1'b0, 1'b1, WIDTH'(15));
        @(posedge clk);
        #1;
        chk("mid_load15_q", 32'(q), 32'd15);
        drive(1'b1, 1'b1, 1'b0, 1'b0, WIDTH'(3));
        #1;
        chk("mid_cet_low_tc", 32'(tc), 32'd0);
        cet = 1'b1;
        #1;
        chk("mid_cet_high_tc", 32'(tc), 32'd1);
        mr = 1'b0; pe = 1'b0; cep = 1'b1; d = WIDTH'(2);
        #1;
        chk("mid_other_inputs_tc", 32'(tc), 32'd1);
        chk("mid_other_inputs_q", 32'(q), 32'd15);
        drive(1'b1, 1'b1, 1'b0, 1'b1, '0);
        @(posedge clk);
        #1;
        chk("mid_after_edge_hold_q", 32'(q), 32'd15);

        // Randomized run with periodic loads and occasional resets.
        drive(1'b0, 1'b1, 1'b0, 1'b0, '0);
        @(posedge clk);
        #1;
        model_q = 0;
        chk("rand_init_q", 32'(q), 32'(model_q));
        for (int i = 0; i < 200; i++) begin
            logic m, p, ep, et;
            logic [WIDTH-1:0] dv;
            m  = ($urandom_range(0, 39) != 0);
            p  = !((i % 10) == 3);
            ep = ($urandom_range(0, 3) != 0);
            et = ($urandom_range(0, 3) != 0);
            dv = WIDTH'($urandom);
            drive(m, p, ep, et, dv);
            model_q = model_next(model_q, m, p, ep, et, int'(dv));
            @(posedge clk);
            #1;
            exp_tc = cet && (model_q == MODULUS - 1);
            chk($sformatf("rand_q_%0d", i), 32'(q), 32'(model_q));
            chk($sformatf("rand_tc_%0d", i), 32'(tc), 32'(exp_tc));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hc_161.md
HC_161 -- requirements
Module: hc_161

Interface
REQ-001 The module SHALL have one parameter: WIDTH, default 4, counter and data width in bits; all values below assume WIDTH=4.
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-003 The module SHALL have port mr, input, 1 bit: master reset, synchronous and active-low.
REQ-004 The module SHALL have port cep, input, 1 bit: count enable parallel, active-high.
REQ-005 The module SHALL have port cet, input, 1 bit: count enable trickle, active-high; also gates tc.
REQ-006 The module SHALL have port pe, input, 1 bit: parallel load enable, active-low.
REQ-007 The module SHALL have port d, input, WIDTH bits: parallel load data.
REQ-008 The module SHALL have port q, output, WIDTH bits: registered counter value.
REQ-009 The module SHALL have port tc, output, 1 bit: terminal count, combinational.
REQ-010 Positional port order SHALL be q, tc, mr, clk, cep, cet, pe, d.

Function
REQ-011 On each rising clk edge, the next state SHALL follow this priority: mr=0 -> q=0; else pe=0 -> q=d; else cep=1 and cet=1 -> q=q+1; else q holds.
REQ-012 Parallel load SHALL take effect regardless of cep and cet.
REQ-013 Increment SHALL be modulo 2^WIDTH: 15 -> 0, with no carry kept.
REQ-014 Counting SHALL require both enables high; either enable low -> hold.
REQ-015 Latency SHALL be one clock for every action: a load, increment or reset is visible on q after that edge, with no extra pipeline.
REQ-016 tc SHALL equal cet AND (q == all ones), evaluated combinationally from the current q.
REQ-017 tc SHALL NOT depend on cep, pe, mr or d.
REQ-018 Input changes between clock edges SHALL NOT affect q; only tc follows cet immediately.
REQ-019 When mr and pe are low at the same edge, reset SHALL win: q=0.
REQ-020 When pe is low with cep=cet=1 at the same edge, load SHALL win: q=d, not d+1.
REQ-021 Loading d=15 with cet=1 SHALL raise tc in the cycle after the load edge.

Reset
REQ-022 Reset SHALL be synchronous only: mr low clears q at the next rising edge; there is no asynchronous path.
REQ-023 The reset value of q SHALL be 0; tc therefore reads 0 after reset.
REQ-024 Before the first reset edge, q SHALL be undefined and the design SHALL NOT rely on an initial value.
REQ-025 Reset asserted mid-count SHALL abort the count; counting resumes from 0 on the first edge with mr=1 and the enables high.

Structure
REQ-026 No shared package SHALL be required; WIDTH SHALL be a module parameter, and the all-ones constant SHALL be derived from WIDTH.
REQ-027 The design SHALL be one flat module with one WIDTH-bit register and combinational tc; no sub-module.

Verification (clk period 10 ns, rising edges at 5, 15, 25 ns, ...)
REQ-028 Reset: mr=0 for two edges with pe=1, cep=cet=1 -> q=0, tc=0; after mr=1, q=1, 2, 3 on successive edges.
REQ-029 Load priority: pe=0, d=9, cep=cet=1 -> q=9 after the edge (not 10); with pe=1 the next edges give 10, 11.
REQ-030 Wrap and tc: load d=14, then count -> q=15 with tc=1 while cet=1; next edge q=0, tc=0; dropping cet at q=15 -> tc=0 and q holds 15.
REQ-031 Enable gating: at q=5, cep=0 with cet=1 for 4 edges -> q stays 5; cet=0 with cep=1 -> q stays 5; both high -> q=6.
REQ-032 Simultaneous events: mr=0 and pe=0 with d=7 at one edge -> q=0; pseudo-random d with periodic pe pulses (about 20 load cycles) -> q matches a reference model every cycle.
